request_queue: RTL and testbench
================================

REQUEST_QUEUE -- requirements
Module: request_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of queue entries (power of two, 2..64).
REQ-002 SHALL have parameter STARVE_LIMIT, default 100, head-entry age (cycles) at or above which starved asserts.
REQ-003 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_req  input  parser_out_struct  request from parser; op_ready_s is the valid strobe.
REQ-006 SHALL have port in_ready  output  1  high when the queue can accept a request (not full).
REQ-007 SHALL have port out_req  output  parser_out_struct  head (oldest) entry, life field carrying current age.
REQ-008 SHALL have port out_valid  output  1  head entry present (not empty).
REQ-009 SHALL have port out_pop  input  1  scheduler consumes head entry this cycle.
REQ-010 SHALL have port occupancy  output  $clog2(DEPTH)+1  number of valid entries.
REQ-011 SHALL have ports full, empty  output  1 each  occupancy==DEPTH, occupancy==0.
REQ-012 SHALL have port starved  output  1  out_valid and head life >= STARVE_LIMIT.

Function
REQ-013 SHALL be a circular buffer: write pointer, read pointer, occupancy counter, all log2(DEPTH)-bit pointers wrapping DEPTH-1 -> 0.
REQ-014 SHALL accept a push when in_req.op_ready_s=1, in_req.opcode!=NOP, and full=0 at the clock edge; otherwise input discarded (producer holds request).
REQ-015 SHALL ignore requests with opcode NOP regardless of op_ready_s.
REQ-016 SHALL store CPU_clock_count, opcode, address unchanged; stored op_ready_s forced 1, life forced 0 at push.
REQ-017 SHALL perform a pop when out_pop=1 and empty=0; out_pop while empty SHALL be ignored with no state change.
REQ-018 SHALL make a pushed entry visible on out_req/out_valid one cycle after the accepting edge (no input-to-output bypass).
REQ-019 SHALL, on simultaneous accepted push and pop, leave occupancy unchanged and advance both pointers.
REQ-020 SHALL, when full and out_pop=1, still reject the push that cycle (in_ready depends only on occupancy, no combinational path from out_pop).
REQ-021 SHALL present out_req with op_ready_s=0, opcode=NOP, address=0, life=0 whenever empty.
REQ-022 SHALL keep entry order strictly FIFO; no reordering.
REQ-023 SHALL drive full, empty, in_ready, out_valid, occupancy, starved from registered state only.

Reset
REQ-024 SHALL, on reset_n low, immediately clear pointers, occupancy and all entry life fields to 0; entry payloads may be left undefined.
REQ-025 SHALL, during and after reset, drive occupancy=0, empty=1, full=0, in_ready=1, out_valid=0, starved=0, out_req per REQ-021.
REQ-026 SHALL, on reset asserted mid-operation, discard all queued entries; no push or pop occurs in the cycle reset is released asynchronously.

Configuration
REQ-027 SHALL honour macro REQUEST_QUEUE_AGING_EN.
REQ-028 SHALL, with REQUEST_QUEUE_AGING_EN defined, increment life of every valid entry by 1 on each clock edge after its push edge, saturating at 127.
REQ-029 SHALL, without REQUEST_QUEUE_AGING_EN, hold every life at 0 and tie starved to 0; STARVE_LIMIT unused.

Verification
REQ-030 SHALL verify: reset released, push READ addr 0x0000_1240 -> next cycle out_valid=1, out_req.address=0x0000_1240, occupancy=1, life=0.
REQ-031 SHALL verify: 16 pushes, no pops -> full=1, in_ready=0; 17th push (addr 0xDEAD_0000) dropped; 16 pops return addresses in push order, then empty=1.
REQ-032 SHALL verify: full queue, push and out_pop same cycle -> occupancy 15, new request not stored; push next cycle accepted, occupancy 16.
REQ-033 SHALL verify: op_ready_s=1 with opcode NOP -> occupancy stays 0; out_pop on empty -> pointers unchanged.
REQ-034 SHALL verify (aging on, STARVE_LIMIT=100): one entry held 100 cycles -> life=100, starved=1; held 200 cycles -> life=127; pop -> starved=0.
REQ-035 SHALL verify: 5 entries queued, reset_n pulsed low mid-cycle -> outputs at reset values immediately; subsequent push appears as sole entry.

Source files
------------

// File: rtl/request_queue.sv
// rtl/request_queue.sv - circular request FIFO with optional head aging (REQUEST_QUEUE_AGING_EN)
package request_queue_pkg;
  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    ERASE = 2'd3
  } opcode_e;

  typedef struct packed {
    logic [31:0] CPU_clock_count;
    opcode_e     opcode;
    logic [31:0] address;
    logic        op_ready_s;
    logic [6:0]  life;
  } parser_out_struct;
endpackage

module request_queue
  import request_queue_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int STARVE_LIMIT = 100
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  parser_out_struct         in_req,
  output logic                     in_ready,
  output parser_out_struct         out_req,
  output logic                     out_valid,
  input  logic                     out_pop,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty,
  output logic                     starved
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  parser_out_struct mem [DEPTH];
  logic [6:0]       life [DEPTH];
  parser_out_struct wdata;
  logic             push;
  logic             pop;
  logic [6:0]       head_life;

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign occupancy = count;

  // Full is judged on registered occupancy, so a same-cycle pop never frees a slot for the push.
  assign push = in_req.op_ready_s && (in_req.opcode != NOP) && !full;
  assign pop  = out_pop && !empty;

  always_comb begin
    wdata            = in_req;
    wdata.op_ready_s = 1'b1;
    wdata.life       = 7'd0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; only life fields need a known value.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

`ifdef REQUEST_QUEUE_AGING_EN
  localparam bit AGING_EN = 1'b1;
  logic [DEPTH-1:0] live;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = ({1'b0, PW'(i) - rd_ptr} < count);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) life[i] <= 7'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (PW'(i) == wr_ptr))
          life[i] <= 7'd0;
        else if (live[i] && (life[i] != 7'd127))
          life[i] <= life[i] + 7'd1;
      end
    end
  end
`else
  localparam bit AGING_EN = 1'b0;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) life[i] = 7'd0;
  end
`endif

  assign head_life = life[rd_ptr];
  assign starved   = AGING_EN && out_valid && (int'(head_life) >= STARVE_LIMIT);

  always_comb begin
    if (empty) begin
      out_req = '0;
    end else begin
      out_req      = mem[rd_ptr];
      out_req.life = head_life;
    end
  end

endmodule

// File: tb/tb_request_queue.sv
// tb/tb_request_queue.sv - directed self-checking bench for request_queue
module tb_request_queue;
  import request_queue_pkg::*;

`ifdef REQUEST_QUEUE_AGING_EN
  localparam int AGING = 1;
`else
  localparam int AGING = 0;
`endif

  logic             clock;
  logic             reset_n;
  parser_out_struct in_req;
  logic             in_ready;
  parser_out_struct out_req;
  logic             out_valid;
  logic             out_pop;
  logic [4:0]       occupancy;
  logic             full;
  logic             empty;
  logic             starved;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] cc = 32'd100;

  request_queue #(.DEPTH(16), .STARVE_LIMIT(100)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_req    (in_req),
    .in_ready  (in_ready),
    .out_req   (out_req),
    .out_valid (out_valid),
    .out_pop   (out_pop),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty),
    .starved   (starved)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input opcode_e op, input logic [31:0] addr, input logic rdy);
    cc++;
    in_req = '{CPU_clock_count: cc, opcode: op, address: addr, op_ready_s: rdy, life: 7'h55};
  endtask

  task automatic push(input opcode_e op, input logic [31:0] addr);
    drive(op, addr, 1'b1);
    step();
    in_req.op_ready_s = 1'b0;
  endtask

  task automatic pop_one;
    out_pop = 1'b1;
    step();
    out_pop = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".occupancy"}, 64'(occupancy), 64'd0);
    check({tag, ".empty"},     64'(empty),     64'd1);
    check({tag, ".full"},      64'(full),      64'd0);
    check({tag, ".in_ready"},  64'(in_ready),  64'd1);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".starved"},   64'(starved),   64'd0);
    check({tag, ".out_req"},   64'(out_req.op_ready_s) | (64'(out_req.opcode) << 1)
                               | (64'(out_req.address) << 8) | (64'(out_req.life) << 40), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    out_pop = 1'b0;
    in_req  = '0;
    #2;
    check_idle("reset_held");
    step();
    step();
    reset_n = 1'b1;
    check_idle("reset_released");

    // single READ becomes visible one cycle after the accepting edge
    drive(READ, 32'h0000_1240, 1'b1);
    #2;
    check("no_bypass.out_valid", 64'(out_valid), 64'd0);
    step();
    in_req.op_ready_s = 1'b0;
    check("first.out_valid", 64'(out_valid), 64'd1);
    check("first.address", 64'(out_req.address), 64'h1240);
    check("first.occupancy", 64'(occupancy), 64'd1);
    check("first.life", 64'(out_req.life), 64'd0);
    check("first.opcode", 64'(out_req.opcode), 64'(READ));
    check("first.op_ready_s", 64'(out_req.op_ready_s), 64'd1);
    check("first.cpu_count", 64'(out_req.CPU_clock_count), 64'd101);
    pop_one();
    check("first_pop.empty", 64'(empty), 64'd1);

    // NOP and non-strobed requests are ignored; pop on empty is harmless
    push(NOP, 32'h0000_9999);
    check("nop.occupancy", 64'(occupancy), 64'd0);
    drive(WRITE, 32'h0000_8888, 1'b0);
    step();
    check("no_strobe.occupancy", 64'(occupancy), 64'd0);
    pop_one();
    check("empty_pop.occupancy", 64'(occupancy), 64'd0);
    check("empty_pop.empty", 64'(empty), 64'd1);
    push(WRITE, 32'h0000_3333);
    check("after_empty_pop.address", 64'(out_req.address), 64'h3333);
    check("after_empty_pop.opcode", 64'(out_req.opcode), 64'(WRITE));
    pop_one();

    // fill to 16, overflow push dropped, drain in order across the wrap
    for (int i = 0; i < 16; i++) begin
      push(READ, 32'h0000_1000 + 32'(i * 16));
      check($sformatf("fill.occupancy[%0d]", i), 64'(occupancy), 64'(i + 1));
    end
    check("full.full", 64'(full), 64'd1);
    check("full.in_ready", 64'(in_ready), 64'd0);
    push(READ, 32'hDEAD_0000);
    check("overflow.occupancy", 64'(occupancy), 64'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain.address[%0d]", i), 64'(out_req.address), 64'h1000 + 64'(i * 16));
      pop_one();
    end
    check("drained.empty", 64'(empty), 64'd1);
    check("drained.occupancy", 64'(occupancy), 64'd0);

    // full queue with simultaneous push and pop: push rejected, retried next cycle
    for (int i = 0; i < 16; i++) push(ERASE, 32'h0000_2000 + 32'(i));
    check("refill.full", 64'(full), 64'd1);
    drive(READ, 32'hBEEF_0000, 1'b1);
    out_pop = 1'b1;
    step();
    out_pop = 1'b0;
    check("full_pushpop.occupancy", 64'(occupancy), 64'd15);
    check("full_pushpop.head", 64'(out_req.address), 64'h2001);
    step();
    in_req.op_ready_s = 1'b0;
    check("retry.occupancy", 64'(occupancy), 64'd16);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("retry_drain.address[%0d]", i), 64'(out_req.address), 64'h2000 + 64'(i));
      pop_one();
    end
    check("retry_drain.tail", 64'(out_req.address), 64'hBEEF_0000);
    pop_one();
    check("retry_drain.empty", 64'(empty), 64'd1);

    // aging and starvation on a single held entry
    push(READ, 32'h0000_5000);
    for (int i = 0; i < 99; i++) step();
    check("age99.life", 64'(out_req.life), 64'(AGING * 99));
    check("age99.starved", 64'(starved), 64'd0);
    step();
    check("age100.life", 64'(out_req.life), 64'(AGING * 100));
    check("age100.starved", 64'(starved), 64'(AGING));
    for (int i = 0; i < 100; i++) step();
    check("age200.life", 64'(out_req.life), 64'(AGING * 127));
    check("age200.address", 64'(out_req.address), 64'h5000);
    pop_one();
    check("aged_pop.starved", 64'(starved), 64'd0);
    check("aged_pop.empty", 64'(empty), 64'd1);

    // asynchronous reset mid-cycle with five entries queued
    for (int i = 0; i < 5; i++) push(WRITE, 32'h0000_6000 + 32'(i));
    check("pre_reset.occupancy", 64'(occupancy), 64'd5);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("async_reset");
    #1;
    reset_n = 1'b1;
    push(READ, 32'h0000_7777);
    check("post_reset.occupancy", 64'(occupancy), 64'd1);
    check("post_reset.address", 64'(out_req.address), 64'h7777);
    check("post_reset.life", 64'(out_req.life), 64'd0);
    pop_one();
    check("post_reset.empty", 64'(empty), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
